rv_hex_periph: RTL

//  Memory-mapped responder for the core's peripheral window: control register at 0x8000_0000, HEX data register at 0x8000_0004.

---
 rtl/rv_hex_periph.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rv_hex_periph.sv
// Memory-mapped CTRL/DATA responder driving an 8-digit multiplexed 7-segment display.
// Optional leading-zero blanking is enabled by defining HEX_LZB_EN.
module rv_hex_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned SCAN_DIV  = 50000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [6:0]  hex_seg_o,
    output logic [7:0]  hex_an_o
);

    localparam int unsigned    CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [31:0]    DATA_ADDR = BASE_ADDR + 32'd4;
    localparam logic [31:0]    CTRL_BITS = 32'h0000_FF01;
    localparam logic [31:0]    CTRL_RST  = 32'h0000_FF01;
    localparam logic [6:0]     SEG_OFF   = 7'h7F;
    localparam logic [7:0]     AN_OFF    = 8'hFF;

    logic [31:0]      ctrl_q;
    logic [31:0]      data_q;
    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       digit_idx;

    logic        sel_ctrl;
    logic        sel_data;
    logic [31:0] upper_bits;
    logic        digit_lit;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign sel_ctrl = (addr_i[31:2] == BASE_ADDR[31:2]);
    assign sel_data = (addr_i[31:2] == DATA_ADDR[31:2]);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        upper_bits = data_q >> {digit_idx, 2'b00};
        digit_lit  = ctrl_q[0] & ctrl_q[8 + digit_idx];
`ifdef HEX_LZB_EN
        if (digit_idx != 3'd0 && upper_bits == 32'd0) digit_lit = 1'b0;
`else
        digit_lit  = digit_lit & 1'b1;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ctrl_q    <= CTRL_RST;
            data_q    <= 32'd0;
            rvalid_o  <= 1'b0;
            rdata_o   <= 32'd0;
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
            hex_seg_o <= SEG_OFF;
            hex_an_o  <= AN_OFF;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= 32'd0;
            if (req_i) begin
                if (we_i) begin
                    if (sel_ctrl)      ctrl_q <= merge_bytes(ctrl_q, wdata_i, be_i) & CTRL_BITS;
                    else if (sel_data) data_q <= merge_bytes(data_q, wdata_i, be_i);
                end else if (sel_ctrl) begin
                    rdata_o <= ctrl_q;
                end else if (sel_data) begin
                    rdata_o <= data_q;
                end
            end

            // Free-running scan; EN only gates the outputs, never the phase.
            if (scan_cnt == CNT_LAST) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                scan_cnt  <= scan_cnt + 1'b1;
            end

            if (digit_lit) begin
                hex_an_o  <= ~(8'd1 << digit_idx);
                hex_seg_o <= seg_decode(upper_bits[3:0]);
            end else begin
                hex_an_o  <= AN_OFF;
                hex_seg_o <= SEG_OFF;
            end
        end
    end

endmodule
